// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer.
// It collects one bit for each cycle that shift_en is high and builds WIDTH-bit words.
// Each finished word goes into a holding register, which drives a valid/ready handshake.
// frame_start realigns the word boundary.
// A word that completes while the holding register is still occupied is dropped,
// and the drop is recorded in the sticky overrun flag.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     shift_en,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sreg_shift;
  logic [WIDTH-1:0] sreg_fresh;
  logic             complete;
  logic             transfer;
  logic             load;

  // Shifted and freshly-framed versions of the shift register for the current bit
  always_comb begin
    sreg_shift = sreg_q;
    sreg_fresh = '0;
    if (MSB_FIRST) begin
      sreg_shift    = {sreg_q[WIDTH-2:0], serial_in};
      sreg_fresh[0] = serial_in;
    end else begin
      sreg_shift       = {serial_in, sreg_q[WIDTH-1:1]};
      sreg_fresh[WIDTH-1] = serial_in;
    end
  end

  // Word completion and handshake qualifiers
  always_comb begin
    // A framing bit always starts a new word, so it can never complete one
    complete = shift_en && !frame_start && (cnt_q == LastBit);
    transfer = valid_q && out_ready;
    load     = complete && (!valid_q || out_ready);
  end

  // Next-state for shift register and bit counter
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (frame_start) begin
      if (shift_en) begin
        sreg_d = sreg_fresh;
        cnt_d  = CntW'(1);
      end else begin
        sreg_d = '0;
        cnt_d  = '0;
      end
    end else if (shift_en) begin
      sreg_d = sreg_shift;
      cnt_d  = (cnt_q == LastBit) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Next-state for holding register, valid and sticky overrun
  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      // The completed word includes the bit being presented this cycle
      hold_d  = sreg_shift;
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
    if (complete && valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = hold_q;
  assign out_valid    = valid_q;
  assign overrun      = overrun_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer.
// Two instances share all inputs: one assembles MSB first, the other LSB first.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       shift_en;
  logic       frame_start;
  logic       out_ready;
  logic [7:0] po_m, po_l;
  logic       vld_m, vld_l;
  logic       ovr_m, ovr_l;
  logic [2:0] bc_m, bc_l;

  int tests_run = 0;
  int tests_failed = 0;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .frame_start  (frame_start),
    .parallel_out (po_m),
    .out_valid    (vld_m),
    .out_ready    (out_ready),
    .overrun      (ovr_m),
    .bit_count    (bc_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .frame_start  (frame_start),
    .parallel_out (po_l),
    .out_valid    (vld_l),
    .out_ready    (out_ready),
    .overrun      (ovr_l),
    .bit_count    (bc_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then settle 1 time unit after the rising edge
  task automatic cyc(input logic sin, input logic en, input logic fs);
    serial_in   = sin;
    shift_en    = en;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] aa, cc, f0, v5a;

  initial begin
    aa  = 8'hAA;
    cc  = 8'hCC;
    f0  = 8'hF0;
    v5a = 8'h5A;
    rst = 1'b1;
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("reset_po", 32'(po_m), 32'h0);
    chk("reset_valid", 32'(vld_m), 32'h0);
    chk("reset_overrun", 32'(ovr_m), 32'h0);
    chk("reset_bitcount", 32'(bc_m), 32'h0);

    // Continuous stream of 0xAA with downstream always ready
    for (int i = 7; i >= 1; i--) cyc(aa[i], 1'b1, 1'b0);
    chk("t1_bc7", 32'(bc_m), 32'd7);
    chk("t1_not_valid_early", 32'(vld_m), 32'h0);
    cyc(aa[0], 1'b1, 1'b0);
    chk("t1_po", 32'(po_m), 32'hAA);
    chk("t1_valid", 32'(vld_m), 32'h1);
    chk("t1_bc_wrap", 32'(bc_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t1_valid_one_cycle", 32'(vld_m), 32'h0);
    chk("t1_overrun", 32'(ovr_m), 32'h0);

    // Same word with two idle cycles between qualified bits
    for (int i = 7; i >= 1; i--) begin
      cyc(aa[i], 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      if (i == 5) chk("t2_bc_hold", 32'(bc_m), 32'd3);
    end
    chk("t2_not_valid_early", 32'(vld_m), 32'h0);
    cyc(aa[0], 1'b1, 1'b0);
    chk("t2_po", 32'(po_m), 32'hAA);
    chk("t2_valid", 32'(vld_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_valid_drop", 32'(vld_m), 32'h0);

    // Three stray bits, then realign on the first bit of 0xCC
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(cc[7], 1'b1, 1'b1);
    chk("t3_bc_after_frame", 32'(bc_m), 32'd1);
    for (int i = 6; i >= 1; i--) cyc(cc[i], 1'b1, 1'b0);
    chk("t3_no_partial_word", 32'(vld_m), 32'h0);
    cyc(cc[0], 1'b1, 1'b0);
    chk("t3_po", 32'(po_m), 32'hCC);
    chk("t3_valid", 32'(vld_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);

    // Downstream stalled: second word is dropped and overrun sticks
    out_ready = 1'b0;
    for (int i = 7; i >= 0; i--) cyc(aa[i], 1'b1, 1'b0);
    chk("t4_first_valid", 32'(vld_m), 32'h1);
    chk("t4_first_overrun", 32'(ovr_m), 32'h0);
    for (int i = 7; i >= 0; i--) cyc(f0[i], 1'b1, 1'b0);
    chk("t4_valid_held", 32'(vld_m), 32'h1);
    chk("t4_po_held", 32'(po_m), 32'hAA);
    chk("t4_overrun", 32'(ovr_m), 32'h1);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("t4_valid_cleared", 32'(vld_m), 32'h0);
    chk("t4_overrun_sticky", 32'(ovr_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_overrun_still", 32'(ovr_m), 32'h1);

    // Accept and reload in the same cycle
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t5_overrun_reset", 32'(ovr_m), 32'h0);
    for (int i = 7; i >= 0; i--) cyc(aa[i], 1'b1, 1'b0);
    chk("t5_first_po", 32'(po_m), 32'hAA);
    for (int i = 7; i >= 1; i--) cyc(cc[i], 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc(cc[0], 1'b1, 1'b0);
    chk("t5_po", 32'(po_m), 32'hCC);
    chk("t5_valid", 32'(vld_m), 32'h1);
    chk("t5_overrun", 32'(ovr_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t5_valid_cleared", 32'(vld_m), 32'h0);

    // Reset mid-word, with shift_en high to exercise reset priority
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_rst_po", 32'(po_m), 32'h0);
    chk("t6_rst_valid", 32'(vld_m), 32'h0);
    chk("t6_rst_overrun", 32'(ovr_m), 32'h0);
    chk("t6_rst_bc", 32'(bc_m), 32'h0);
    chk("t6_rst_bc_lsb", 32'(bc_l), 32'h0);
    // Bits 0,1,0,1,1,0,1,0 form 0x5A both MSB first and LSB first
    for (int i = 7; i >= 0; i--) cyc(v5a[i], 1'b1, 1'b0);
    chk("t6_po_msb", 32'(po_m), 32'h5A);
    chk("t6_valid_msb", 32'(vld_m), 32'h1);
    chk("t6_po_lsb", 32'(po_l), 32'h5A);
    chk("t6_valid_lsb", 32'(vld_l), 32'h1);
    chk("t6_overrun_lsb", 32'(ovr_l), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
